// File: rtl/histeq_pkg.sv
// ============================================================================
// Module      : histeq_pkg
// Description : Shared geometry constants, FSM state type and lane-select
//               helper for the histogram/equalization memory stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package histeq_pkg;

  localparam int ADDR_W       = 16;
  localparam int WORD_W       = 128;
  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = WORD_W / PIX_W;
  localparam int LANE_W       = $clog2(PIX_PER_WORD);
  localparam int CNT_W        = 16;
  localparam int STAT_W       = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Lane k occupies bits [PIX_W*k +: PIX_W]; lane 0 is the first pixel out.
  function automatic logic [PIX_W-1:0] lane_sel(input logic [WORD_W-1:0] w,
                                                input logic [LANE_W-1:0] k);
    return w[k*PIX_W +: PIX_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/input_word_fifo.sv
// ============================================================================
// Module      : input_word_fifo
// Description : Two-entry register FIFO holding fetched memory words. Entry 0
//               is always the head; second_o exposes entry 1 so the caller
//               can look ahead across a pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_word_fifo
  import histeq_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] second_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]       count_q, count_d;

  // Next-state: the caller never pushes when full nor pops when empty.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) ent0_d = data_i;
        else                 ent1_d = data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          ent0_d = data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = data_i;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head_o   = ent0_q;
  assign second_o = ent1_q;
  assign count_o  = count_q;

endmodule

`default_nettype wire

// File: rtl/input_word_unpacker.sv
// ============================================================================
// Module      : input_word_unpacker
// Description : Streams packed words from a synchronous word-addressed memory
//               and unpacks them into a valid/ready pixel stream with a
//               last-pixel marker and done pulse. Geometry from histeq_pkg.
//               Optional macro INPUT_UNPACKER_STATS_EN adds pixel_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_word_unpacker
  import histeq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_address,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] ReadAddress,
  output logic              ReadEnable,
  input  logic [WORD_W-1:0] ReadBus,
  output logic [PIX_W-1:0]  PixelOut,
  output logic              PixelValid,
  input  logic              PixelReady,
  output logic              PixelLast,
  output logic              busy,
  output logic              done
`ifdef INPUT_UNPACKER_STATS_EN
  ,
  output logic [STAT_W-1:0] pixel_count
`endif
);

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PIX_PER_WORD - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_pend_q, rd_pend_d;   // read data arriving this cycle
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [CNT_W-1:0]    issue_left_q, issue_left_d;
  logic [CNT_W-1:0]    pop_left_q, pop_left_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef INPUT_UNPACKER_STATS_EN
  logic [STAT_W-1:0]   stat_q, stat_d;
`endif

  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic [1:0]          w_cnt;
  logic [1:0]          w_cnt_next;
  logic [WORD_W-1:0]   w_head;
  logic [WORD_W-1:0]   w_second;
  logic [WORD_W-1:0]   w_head_next;

  input_word_fifo #(.WIDTH(WORD_W)) u_fifo (
    .clk_i    (clock),
    .rst_i    (reset),
    .push_i   (w_push),
    .pop_i    (w_pop),
    .data_i   (ReadBus),
    .head_o   (w_head),
    .second_o (w_second),
    .count_o  (w_cnt)
  );

  // Buffer bookkeeping and the head word as it will look after this edge,
  // so the registered pixel output can be loaded in the same cycle.
  always_comb begin
    w_accept   = valid_q && PixelReady;
    w_pop      = w_accept && (lane_q == LANE_LAST);
    w_push     = rd_pend_q;
    w_cnt_next = w_cnt + {1'b0, w_push} - {1'b0, w_pop};
    case (w_cnt)
      2'd0:    w_head_next = ReadBus;
      2'd1:    w_head_next = w_pop ? ReadBus : w_head;
      default: w_head_next = w_pop ? w_second : w_head;
    endcase
  end

  // FSM next-state, read issue and output-register next values.
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    rd_en_d      = 1'b0;
    rd_pend_d    = rd_en_q;
    next_addr_d  = next_addr_q;
    issue_left_d = issue_left_q;
    pop_left_d   = pop_left_q;
    lane_d       = lane_q;
    pix_d        = pix_q;
    valid_d      = valid_q;
    last_d       = last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
`ifdef INPUT_UNPACKER_STATS_EN
    stat_d       = stat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef INPUT_UNPACKER_STATS_EN
          stat_d = '0;
`endif
          if (word_count == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d      = ST_RUN;
            busy_d       = 1'b1;
            rd_en_d      = 1'b1;
            rd_addr_d    = base_address;
            next_addr_d  = base_address + ADDR_W'(1);
            issue_left_d = word_count - CNT_W'(1);
            pop_left_d   = word_count;
            lane_d       = '0;
          end
        end
      end
      ST_RUN: begin
        if (w_accept) lane_d = lane_q + LANE_W'(1);
        if (w_pop)    pop_left_d = pop_left_q - CNT_W'(1);
`ifdef INPUT_UNPACKER_STATS_EN
        if (w_accept) stat_d = stat_q + STAT_W'(1);
`endif
        // Issue only if the new read still fits: buffered words after this
        // edge plus the read already in flight must leave one free slot.
        if ((issue_left_q != '0) &&
            ((w_cnt_next == 2'd0) || ((w_cnt_next == 2'd1) && !rd_en_q))) begin
          rd_en_d      = 1'b1;
          rd_addr_d    = next_addr_q;
          next_addr_d  = next_addr_q + ADDR_W'(1);
          issue_left_d = issue_left_q - CNT_W'(1);
        end
        valid_d = (w_cnt_next != 2'd0);
        pix_d   = valid_d ? lane_sel(w_head_next, lane_d) : '0;
        last_d  = valid_d && (lane_d == LANE_LAST) && (pop_left_d == CNT_W'(1));
        if (w_accept && last_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          pix_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset also discards any in-flight read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      next_addr_q  <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      lane_q       <= '0;
      pix_q        <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef INPUT_UNPACKER_STATS_EN
      stat_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      rd_pend_q    <= rd_pend_d;
      next_addr_q  <= next_addr_d;
      issue_left_q <= issue_left_d;
      pop_left_q   <= pop_left_d;
      lane_q       <= lane_d;
      pix_q        <= pix_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef INPUT_UNPACKER_STATS_EN
      stat_q       <= stat_d;
`endif
    end
  end

  assign ReadAddress = rd_addr_q;
  assign ReadEnable  = rd_en_q;
  assign PixelOut    = pix_q;
  assign PixelValid  = valid_q;
  assign PixelLast   = last_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef INPUT_UNPACKER_STATS_EN
  assign pixel_count = stat_q;
`endif

endmodule

`default_nettype wire

// File: doc/input_word_unpacker.md
# input_word_unpacker

Reader-side counterpart of the output store stage: streams packed 128-bit image words out of a synchronous word-addressed memory and unpacks them into a pixel stream, one 8-bit pixel per accepted transfer. Feeds the histogram/equalization pipeline with a valid/ready handshake, a last-pixel marker and a done pulse. Lane order matches the packing used by the output store, so a word written there reads back pixel-for-pixel here.

## Interface
Parameters:
- ADDR_W, 16, memory word address width
- WORD_W, 128, memory word width
- PIX_W, 8, pixel width; PIX_PER_WORD = WORD_W/PIX_W (16)

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begins a transfer; sampled only in IDLE
- base_address  in  ADDR_W  first word address, latched on start
- word_count  in  16  number of words to read, latched on start
- ReadAddress  out  ADDR_W  memory word address
- ReadEnable  out  1  read strobe; ReadBus valid the following cycle
- ReadBus  in  WORD_W  memory read data
- PixelOut  out  PIX_W  current pixel
- PixelValid  out  1  PixelOut valid
- PixelReady  in  1  downstream accept; transfer when Valid && Ready
- PixelLast  out  1  high with the final pixel of the transfer
- busy  out  1  high from cycle after start until done
- done  out  1  one-cycle pulse at end of transfer

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start with word_count != 0; IDLE -> DONE on start with word_count == 0 (no reads issued).
- RUN: issue reads at base_address, base_address+1, ... modulo 2^ADDR_W; stop after word_count reads.
- Read issue rule: ReadEnable asserted only when (buffered words + reads in flight) < 2; never overruns the 2-entry word buffer.
- Returned word captured into buffer the cycle after its ReadEnable, unconditionally.
- Unpack: pixel k = word[PIX_W*k+PIX_W-1 : PIX_W*k], k = 0..15 in increasing order.
- Lane counter (4 bits) advances on each Valid && Ready; on lane 15 accept, head word pops.
- PixelLast = last lane of last word. RUN -> DONE on the accepted PixelLast transfer; DONE -> IDLE next cycle.
- PixelOut/PixelLast hold stable while PixelValid && !PixelReady.
- start outside IDLE ignored; base_address/word_count changes after start ignored.
- Reset (any time, including mid-stream): state IDLE, buffer empty, counters 0, in-flight read discarded; no done.
- Reset values: ReadAddress 0, ReadEnable 0, PixelOut 0, PixelValid 0, PixelLast 0, busy 0, done 0.

## Timing
- Cycle 0 start sampled; cycle 1 ReadEnable=1, ReadAddress=base; cycle 2 ReadBus valid, captured at cycle-2 edge; cycle 3 PixelValid=1 with pixel 0. First-pixel latency 3 cycles.
- PixelReady held high: one pixel per cycle, no bubbles between words (second word prefetched while first drains).
- done pulses the cycle after the PixelLast transfer; busy falls same cycle done rises.
- word_count == 0: done pulses in cycle 1; busy never asserts.
- All outputs registered.

## Configuration
- INPUT_UNPACKER_STATS_EN: when defined, adds output pixel_count (out, 20 bits), cleared on start, incremented per accepted pixel, holding the final count until next start; reset 0. When undefined, port and counter absent; all other behaviour identical.

## Structure
- Shared package histeq_pkg: WORD_W, PIX_W, PIX_PER_WORD, ADDR_W constants and the state enum type (IDLE/RUN/DONE).
- Sub-module input_word_fifo: 2-deep WORD_W register FIFO with push/pop/count; top holds FSM, address/issue counters, lane counter and output registers.

## Test plan
- base=0x0010, count=1, word byte k = k, Ready=1 -> single read at 0x0010 in cycle 1; PixelOut 0x00..0x0F on cycles 3..18; PixelLast on 0x0F; done on cycle 19.
- count=0 -> ReadEnable never high; done pulses cycle 1; no PixelValid.
- count=4, Ready random 50% -> 64 pixels in order, values stable while stalled, buffered+in-flight never exceeds 2.
- base=0xFFFF, count=2 -> ReadAddress 0xFFFF then 0x0000; 32 pixels correct.
- reset asserted after 5th accepted pixel of count=3 -> all outputs 0 next sample, no done; fresh start afterwards produces complete correct stream.
- start pulsed again while busy with different base -> ignored; original address sequence and single done unchanged.
